// File: rtl/riscv_structures.sv
// Shared pipeline structures: stage-to-stage registers and the MEM stage FSM encoding.
package riscv_structures;

    // Execute -> memory pipeline register contents.
    typedef struct packed {
        logic        mem_write;
        logic        mem_read;
        logic        reg_write;
        logic [4:0]  rd;
        logic [31:0] mem_data;
        logic [31:0] alu_result;
    } ex_to_mem_s;

    // Memory -> writeback pipeline register contents.
    typedef struct packed {
        logic        reg_write;
        logic [4:0]  rd;
        logic [31:0] result;
    } mem_to_wb_s;

    // Memory stage control: idle/issuing, or waiting for a load response.
    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_RSP = 1'b1
    } mem_state_e;

    // Word accesses only: any nonzero low address bits is a fault.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_timeout_counter.sv
// Saturating wait counter for outstanding loads; flags when the response budget is used up.
module dmem_timeout_counter #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned          CW   = $clog2(MAX_WAIT);
    localparam logic [CW-1:0]        LAST = CW'(MAX_WAIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired = (cnt_q == LAST);

    // Next count: clear wins, otherwise count up and hold at the last value.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/memory_stage.sv
// MEM stage: word loads/stores over a valid/ready data port, WB register, bypass and stall.
module memory_stage
    import riscv_structures::*;
#(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  ex_to_mem_s  ex_to_mem,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rsp_rdata,
    output mem_to_wb_s  mem_to_wb,
    output logic [31:0] bp_mem,
    output logic        stall_mem,
    output logic        mem_err
);

    mem_state_e state_q, state_d;
    mem_to_wb_s wb_q, wb_d;
    logic       err_q, err_d;

    logic       cnt_clear;
    logic       cnt_en;
    logic       cnt_expired;

    logic       is_mem_op;
    logic       misaligned;
    logic       req_valid_raw;
    logic       we_raw;
    logic       stall_raw;

    assign is_mem_op  = ex_to_mem.mem_write || ex_to_mem.mem_read;
    assign misaligned = is_misaligned(ex_to_mem.alu_result);

    assign dmem_addr  = ex_to_mem.alu_result;
    assign dmem_wdata = ex_to_mem.mem_data;
    assign bp_mem     = ex_to_mem.alu_result;

    // Request and stall are forced low while reset is asserted, independent of state.
    assign dmem_req_valid = req_valid_raw && rst_n;
    assign dmem_we        = we_raw && rst_n;
    assign stall_mem      = stall_raw && rst_n;

    assign mem_to_wb = wb_q;
    assign mem_err   = err_q;

    dmem_timeout_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (cnt_clear),
        .enable  (cnt_en),
        .expired (cnt_expired)
    );

    // Next-state, request/stall outputs and the value headed into WB.
    always_comb begin
        state_d       = state_q;
        req_valid_raw = 1'b0;
        we_raw        = 1'b0;
        stall_raw     = 1'b0;
        err_d         = 1'b0;
        cnt_clear     = 1'b0;
        cnt_en        = 1'b0;
        wb_d.reg_write = ex_to_mem.reg_write;
        wb_d.rd        = ex_to_mem.rd;
        wb_d.result    = ex_to_mem.alu_result;

        unique case (state_q)
            IDLE: begin
                if (is_mem_op) begin
                    wb_d.reg_write = 1'b0;
                    if (misaligned) begin
                        err_d = 1'b1;
                    end else if (ex_to_mem.mem_write) begin
                        req_valid_raw = 1'b1;
                        we_raw        = 1'b1;
                        stall_raw     = !dmem_req_ready;
                    end else begin
                        req_valid_raw = 1'b1;
                        stall_raw     = 1'b1;
                        if (dmem_req_ready) begin
                            state_d   = WAIT_RSP;
                            cnt_clear = 1'b1;
                        end
                    end
                end
            end

            WAIT_RSP: begin
                cnt_en         = 1'b1;
                wb_d.reg_write = 1'b0;
                if (dmem_rsp_valid) begin
                    wb_d.reg_write = ex_to_mem.reg_write;
                    wb_d.result    = dmem_rsp_rdata;
                    state_d        = IDLE;
                end else if (cnt_expired) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall_raw = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, WB register and error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wb_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wb_q    <= wb_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage with a short response budget.
module tb_memory_stage;
    import riscv_structures::*;

    logic        clk;
    logic        rst_n;
    ex_to_mem_s  ex_to_mem;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rsp_rdata;
    mem_to_wb_s  mem_to_wb;
    logic [31:0] bp_mem;
    logic        stall_mem;
    logic        mem_err;

    int n_tests = 0;
    int n_fail  = 0;

    memory_stage #(
        .MAX_WAIT (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_to_mem      (ex_to_mem),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rsp_rdata (dmem_rsp_rdata),
        .mem_to_wb      (mem_to_wb),
        .bp_mem         (bp_mem),
        .stall_mem      (stall_mem),
        .mem_err        (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ex(input logic mw, input logic mr, input logic rw,
                          input logic [4:0] rd, input logic [31:0] data,
                          input logic [31:0] alu);
        ex_to_mem.mem_write  = mw;
        ex_to_mem.mem_read   = mr;
        ex_to_mem.reg_write  = rw;
        ex_to_mem.rd         = rd;
        ex_to_mem.mem_data   = data;
        ex_to_mem.alu_result = alu;
    endtask

    // Advance one clock and land 1 time unit past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wb(input string tag, input logic rw, input logic [4:0] rd,
                          input logic [31:0] res);
        chk({tag, ".rw"}, 64'(mem_to_wb.reg_write), 64'(rw));
        chk({tag, ".rd"}, 64'(mem_to_wb.rd), 64'(rd));
        chk({tag, ".res"}, 64'(mem_to_wb.result), 64'(res));
    endtask

    initial begin
        rst_n          = 1'b0;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        dmem_rsp_rdata = '0;
        set_ex(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        #2;
        chk("rst.wb", 64'(mem_to_wb), 64'h0);
        chk("rst.err", 64'(mem_err), 64'h0);
        chk("rst.reqv", 64'(dmem_req_valid), 64'h0);
        chk("rst.stall", 64'(stall_mem), 64'h0);
        tick();
        rst_n = 1'b1;

        // ALU op passes straight through
        set_ex(1'b0, 1'b0, 1'b1, 5'd5, 32'h0, 32'h1234);
        #1;
        chk("alu.stall", 64'(stall_mem), 64'h0);
        chk("alu.reqv", 64'(dmem_req_valid), 64'h0);
        chk("alu.bp", 64'(bp_mem), 64'h1234);
        tick();
        chk_wb("alu.wb", 1'b1, 5'd5, 32'h1234);
        chk("alu.err", 64'(mem_err), 64'h0);

        // Store held off by ready for three cycles
        set_ex(1'b1, 1'b0, 1'b1, 5'd2, 32'hDEADBEEF, 32'h100);
        dmem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("st.stall", 64'(stall_mem), 64'h1);
            chk("st.reqv", 64'(dmem_req_valid), 64'h1);
            chk("st.we", 64'(dmem_we), 64'h1);
            chk("st.addr", 64'(dmem_addr), 64'h100);
            chk("st.wdata", 64'(dmem_wdata), 64'hDEADBEEF);
            tick();
            chk("st.bubble", 64'(mem_to_wb.reg_write), 64'h0);
        end
        dmem_req_ready = 1'b1;
        #1;
        chk("st.acc.stall", 64'(stall_mem), 64'h0);
        chk("st.acc.reqv", 64'(dmem_req_valid), 64'h1);
        chk("st.acc.we", 64'(dmem_we), 64'h1);
        tick();
        chk("st.acc.wbrw", 64'(mem_to_wb.reg_write), 64'h0);
        chk("st.acc.err", 64'(mem_err), 64'h0);

        // Load with response two cycles after accept
        set_ex(1'b0, 1'b1, 1'b1, 5'd7, 32'h0, 32'h200);
        dmem_req_ready = 1'b1;
        #1;
        chk("ld.acc.reqv", 64'(dmem_req_valid), 64'h1);
        chk("ld.acc.we", 64'(dmem_we), 64'h0);
        chk("ld.acc.stall", 64'(stall_mem), 64'h1);
        tick();
        chk("ld.acc.wbrw", 64'(mem_to_wb.reg_write), 64'h0);
        dmem_req_ready = 1'b0;
        #1;
        chk("ld.w1.stall", 64'(stall_mem), 64'h1);
        chk("ld.w1.reqv", 64'(dmem_req_valid), 64'h0);
        tick();
        chk("ld.w1.wbrw", 64'(mem_to_wb.reg_write), 64'h0);
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 32'hCAFEF00D;
        #1;
        chk("ld.rsp.stall", 64'(stall_mem), 64'h0);
        tick();
        chk_wb("ld.wb", 1'b1, 5'd7, 32'hCAFEF00D);
        dmem_rsp_valid = 1'b0;

        // Misaligned load is dropped with an error pulse
        set_ex(1'b0, 1'b1, 1'b1, 5'd8, 32'h0, 32'h203);
        #1;
        chk("mis.reqv", 64'(dmem_req_valid), 64'h0);
        chk("mis.stall", 64'(stall_mem), 64'h0);
        tick();
        chk("mis.err", 64'(mem_err), 64'h1);
        chk("mis.wbrw", 64'(mem_to_wb.reg_write), 64'h0);
        set_ex(1'b0, 1'b0, 1'b1, 5'd3, 32'h0, 32'h55);
        tick();
        chk("mis.err.clr", 64'(mem_err), 64'h0);
        chk_wb("mis.next", 1'b1, 5'd3, 32'h55);

        // Load that never gets a response times out
        set_ex(1'b0, 1'b1, 1'b1, 5'd9, 32'h0, 32'h300);
        dmem_req_ready = 1'b1;
        #1;
        chk("to.acc.stall", 64'(stall_mem), 64'h1);
        tick();
        dmem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("to.wait.stall", 64'(stall_mem), 64'h1);
            tick();
            chk("to.wait.err", 64'(mem_err), 64'h0);
        end
        #1;
        chk("to.last.stall", 64'(stall_mem), 64'h0);
        chk("to.last.reqv", 64'(dmem_req_valid), 64'h0);
        tick();
        chk("to.err", 64'(mem_err), 64'h1);
        chk("to.wbrw", 64'(mem_to_wb.reg_write), 64'h0);
        set_ex(1'b0, 1'b0, 1'b1, 5'd4, 32'h0, 32'h77);
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 32'hBAD;
        #1;
        chk("to.stray.stall", 64'(stall_mem), 64'h0);
        tick();
        chk_wb("to.stray.wb", 1'b1, 5'd4, 32'h77);
        chk("to.err.clr", 64'(mem_err), 64'h0);
        dmem_rsp_valid = 1'b0;

        // Reset asserted while a load is waiting
        set_ex(1'b0, 1'b1, 1'b1, 5'd10, 32'h0, 32'h400);
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        #1;
        chk("rw.wait.stall", 64'(stall_mem), 64'h1);
        chk("rw.wb.pre", 64'(mem_to_wb.result), 64'h400);
        rst_n = 1'b0;
        #1;
        chk("rw.stall", 64'(stall_mem), 64'h0);
        chk("rw.reqv", 64'(dmem_req_valid), 64'h0);
        chk("rw.wb", 64'(mem_to_wb), 64'h0);
        chk("rw.err", 64'(mem_err), 64'h0);
        tick();
        rst_n = 1'b1;
        set_ex(1'b0, 1'b0, 1'b1, 5'd6, 32'h0, 32'h99);
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 32'hBAD;
        #1;
        chk("rw.post.stall", 64'(stall_mem), 64'h0);
        chk("rw.post.reqv", 64'(dmem_req_valid), 64'h0);
        tick();
        chk_wb("rw.post.wb", 1'b1, 5'd6, 32'h99);
        chk("rw.post.err", 64'(mem_err), 64'h0);
        dmem_rsp_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
